logo_scroll_ctrl: RTL and testbench

- Upstream animation controller for the VGA logo painters.
- Generates the 11-bit horizontal offset `delt` that all logo letter painters add to their base X coordinates.
- Advances once per video frame, on the vsync start edge from the VGA timing generator.
- Bounces the logo between 0 and MAX_DELT, with a dwell period at each end.

---
 rtl/logo_scroll_ctrl.sv | 152 +++++++++++++++
 tb/tb_logo_scroll_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/logo_scroll_ctrl.sv
// logo_scroll_ctrl
//   Frame-rate animation controller for the VGA logo painters. Produces the
//   horizontal offset `delt` that every letter painter adds to its base X.
//   The offset advances once per video frame, on the falling edge of vsync.
//   It bounces between 0 and MAX_DELT and dwells PAUSE_FRAMES frames at each end.
//
//   Build option: define LOGO_SCROLL_WRAP_EN for unidirectional wrap mode.
//   In that mode delt runs 0 -> MAX_DELT, then restarts at 0, and dir is tied to 0.
//
// Ports
//   clk        : system clock, same domain as the VGA timing generator
//   rst        : synchronous reset, active-high
//   vsync      : VGA vertical sync, active-low, synchronous to clk
//   enable     : 1 = animate, 0 = freeze
//   delt       : logo X offset (registered)
//   frame_tick : one-cycle pulse marking a frame update (registered)
//   dir        : 0 = moving/dwelling right, 1 = left (registered)
//   moving     : 1 while in a MOVE state and enabled (registered)
module logo_scroll_ctrl #(
  parameter int unsigned MAX_DELT     = 200,
  parameter int unsigned STEP         = 2,
  parameter int unsigned PAUSE_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        enable,
  output logic [10:0] delt,
  output logic        frame_tick,
  output logic        dir,
  output logic        moving
);

  localparam logic [11:0] STEP_W = 12'(STEP);
  localparam logic [11:0] MAX_W  = 12'(MAX_DELT);

`ifdef LOGO_SCROLL_WRAP_EN
  typedef enum logic [0:0] {IDLE, MOVE_R} state_t;
`else
  typedef enum logic [2:0] {IDLE, MOVE_R, PAUSE_R, MOVE_L, PAUSE_L} state_t;
  localparam logic [7:0] PAUSE_W = 8'(PAUSE_FRAMES);
`endif

  state_t      state_q, state_d;
  logic [10:0] delt_q, delt_d;
  logic        vs_q;
  logic        tick;
  logic        frame_tick_q;
  logic        dir_q, dir_d;
  logic        moving_q, moving_d;
  logic [11:0] sum_w;
`ifndef LOGO_SCROLL_WRAP_EN
  logic [7:0]  pause_q, pause_d;
`endif

  // Falling edge of vsync, gated by enable. All state updates use this strobe.
  // The registered frame_tick therefore appears together with the new delt.
  assign tick  = vs_q & ~vsync & enable;
  assign sum_w = {1'b0, delt_q} + STEP_W;

  always_comb begin
    state_d = state_q;
    delt_d  = delt_q;
`ifdef LOGO_SCROLL_WRAP_EN
    if (tick) begin
      case (state_q)
        IDLE:    state_d = MOVE_R;
        MOVE_R:  delt_d  = (sum_w > MAX_W) ? '0 : sum_w[10:0];
        default: state_d = IDLE;
      endcase
    end
    dir_d    = 1'b0;
    moving_d = enable & (state_d != IDLE);
`else
    pause_d = pause_q;
    if (tick) begin
      case (state_q)
        IDLE: state_d = MOVE_R;
        MOVE_R: begin
          if (sum_w >= MAX_W) begin
            delt_d = MAX_W[10:0];
            if (PAUSE_FRAMES == 0) begin
              state_d = MOVE_L;
            end else begin
              state_d = PAUSE_R;
              pause_d = PAUSE_W;
            end
          end else begin
            delt_d = sum_w[10:0];
          end
        end
        PAUSE_R: begin
          pause_d = pause_q - 8'd1;
          if (pause_q == 8'd1) state_d = MOVE_L;
        end
        MOVE_L: begin
          if ({1'b0, delt_q} <= STEP_W) begin
            delt_d = '0;
            if (PAUSE_FRAMES == 0) begin
              state_d = MOVE_R;
            end else begin
              state_d = PAUSE_L;
              pause_d = PAUSE_W;
            end
          end else begin
            delt_d = delt_q - STEP_W[10:0];
          end
        end
        PAUSE_L: begin
          pause_d = pause_q - 8'd1;
          if (pause_q == 8'd1) state_d = MOVE_R;
        end
        default: state_d = IDLE;
      endcase
    end
    // dir and moving are pure functions of the next state. Because the state
    // holds while enable is low, dir stays frozen. moving is masked by enable.
    dir_d    = (state_d == MOVE_L) || (state_d == PAUSE_L);
    moving_d = enable & ((state_d == MOVE_R) || (state_d == MOVE_L));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q         <= 1'b1;
      state_q      <= IDLE;
      delt_q       <= '0;
      frame_tick_q <= 1'b0;
      dir_q        <= 1'b0;
      moving_q     <= 1'b0;
`ifndef LOGO_SCROLL_WRAP_EN
      pause_q      <= '0;
`endif
    end else begin
      vs_q         <= vsync;
      state_q      <= state_d;
      delt_q       <= delt_d;
      frame_tick_q <= tick;
      dir_q        <= dir_d;
      moving_q     <= moving_d;
`ifndef LOGO_SCROLL_WRAP_EN
      pause_q      <= pause_d;
`endif
    end
  end

  assign delt       = delt_q;
  assign frame_tick = frame_tick_q;
  assign dir        = dir_q;
  assign moving     = moving_q;

endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// tb_logo_scroll_ctrl
//   Testbench for logo_scroll_ctrl, configured with MAX_DELT=10, STEP=3 and
//   PAUSE_FRAMES=2. A frame-level reference model tracks position, direction
//   and the remaining dwell frames. Directed scenarios are followed by a
//   random vsync/enable/rst phase.
module tb_logo_scroll_ctrl;

  localparam int unsigned MAXD = 10;
  localparam int unsigned STP  = 3;
  localparam int unsigned PF   = 2;

  logic        clk = 1'b0;
  logic        rst, vsync, enable;
  logic [10:0] delt;
  logic        frame_tick, dir, moving;

  logo_scroll_ctrl #(
    .MAX_DELT    (MAXD),
    .STEP        (STP),
    .PAUSE_FRAMES(PF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .enable     (enable),
    .delt       (delt),
    .frame_tick (frame_tick),
    .dir        (dir),
    .moving     (moving)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tick_seen = 0;

  // Reference model state
  logic        m_vs = 1'b1;
  logic        m_started = 1'b0;
  logic        m_dir = 1'b0;
  int unsigned m_pause = 0;
  int unsigned m_delt = 0;
  logic        m_tick = 1'b0;
  logic        m_moving = 1'b0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one frame.
  task automatic model_frame();
    if (!m_started) begin
      m_started = 1'b1;
      m_dir     = 1'b0;
    end else begin
`ifdef LOGO_SCROLL_WRAP_EN
      m_delt = (m_delt + STP > MAXD) ? 0 : m_delt + STP;
`else
      if (m_pause > 0) begin
        m_pause--;
        if (m_pause == 0) m_dir = ~m_dir;
      end else if (!m_dir) begin
        if (m_delt + STP >= MAXD) begin
          m_delt = MAXD;
          if (PF == 0) m_dir = 1'b1;
          else m_pause = PF;
        end else begin
          m_delt = m_delt + STP;
        end
      end else begin
        if (m_delt <= STP) begin
          m_delt = 0;
          if (PF == 0) m_dir = 1'b0;
          else m_pause = PF;
        end else begin
          m_delt = m_delt - STP;
        end
      end
`endif
    end
  endtask

  // Drive one clock cycle, update the model, then compare all outputs.
  task automatic cycle(input logic r, input logic v, input logic e);
    rst = r; vsync = v; enable = e;
    @(posedge clk);
    if (r) begin
      m_vs = 1'b1; m_started = 1'b0; m_dir = 1'b0; m_pause = 0;
      m_delt = 0; m_tick = 1'b0; m_moving = 1'b0;
    end else begin
      m_tick = m_vs & ~v & e;
      m_vs   = v;
      if (m_tick) model_frame();
`ifdef LOGO_SCROLL_WRAP_EN
      m_moving = e & m_started;
`else
      m_moving = e & m_started & (m_pause == 0);
`endif
    end
    #1;
    if (frame_tick) tick_seen++;
    chk("delt", delt, m_delt);
    chk("frame_tick", frame_tick, m_tick);
    chk("dir", dir, m_dir);
    chk("moving", moving, m_moving);
  endtask

  task automatic frame(input logic e);
    repeat (2) cycle(1'b0, 1'b1, e);
    repeat (2) cycle(1'b0, 1'b0, e);
  endtask

  initial begin
    int unsigned t0;
    rst = 1'b1; vsync = 1'b1; enable = 1'b1;
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    chk("rst_delt", delt, 0);
    chk("rst_moving", moving, 0);

`ifdef LOGO_SCROLL_WRAP_EN
    begin
      int unsigned wexp[6] = '{0, 3, 6, 9, 0, 3};
      for (int unsigned i = 0; i < 6; i++) begin
        frame(1'b1);
        chk("wrap_seq", delt, wexp[i]);
        chk("wrap_dir", dir, 0);
      end
    end
`else
    begin
      int unsigned wexp[9] = '{0, 3, 6, 9, 10, 10, 10, 7, 4};
      int unsigned rexp[5] = '{1, 0, 0, 0, 3};
      int unsigned rdir[5] = '{1, 1, 1, 0, 0};
      for (int unsigned i = 0; i < 9; i++) begin
        frame(1'b1);
        chk("walk_delt", delt, wexp[i]);
        chk("walk_dir", dir, (i >= 6) ? 1 : 0);
        chk("walk_moving", moving, (i == 4 || i == 5) ? 0 : 1);
      end
      // Freeze for 5 frames at delt=4
      t0 = tick_seen;
      repeat (5) frame(1'b0);
      chk("frz_ticks", tick_seen - t0, 0);
      chk("frz_delt", delt, 4);
      chk("frz_moving", moving, 0);
      for (int unsigned i = 0; i < 5; i++) begin
        frame(1'b1);
        chk("resume_delt", delt, rexp[i]);
        chk("resume_dir", dir, rdir[i]);
      end
      // Long low vsync then a one-cycle pulse: exactly two ticks
      t0 = tick_seen;
      repeat (2) cycle(1'b0, 1'b1, 1'b1);
      repeat (20) cycle(1'b0, 1'b0, 1'b1);
      repeat (2) cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b1, 1'b1);
      chk("held_ticks", tick_seen - t0, 2);
      chk("held_delt", delt, 9);
      // Walk to delt=7 moving left: 10, 10, 10(dir=1), 7
      repeat (4) frame(1'b1);
      chk("pre_rst_delt", delt, 7);
      chk("pre_rst_dir", dir, 1);
      // Reset coincident with a vsync falling edge
      repeat (2) cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      chk("rst_mid_delt", delt, 0);
      chk("rst_mid_dir", dir, 0);
      chk("rst_mid_tick", frame_tick, 0);
      repeat (2) cycle(1'b0, 1'b1, 1'b1);
      frame(1'b1);
      chk("rst_idle_exit", delt, 0);
      frame(1'b1);
      chk("rst_first_move", delt, 3);
    end
`endif

    // Random phase
    for (int unsigned i = 0; i < 3000; i++) begin
      logic v, e, r;
      v = ($urandom_range(0, 2) != 0);
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 199) == 0);
      cycle(r, v, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
